param_sync_fifo: RTL
====================

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits, legal range 1 or more.
REQ-002 Parameter DEPTH, default 16, number of entries, power of two, 2 or more.
REQ-003 Parameter AF_THRESH, default DEPTH-2, almost_full asserts when level >= AF_THRESH.
REQ-004 Parameter AE_THRESH, default 2, almost_empty asserts when level <= AE_THRESH.
REQ-005 Parameter FWFT, default 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.
REQ-006 The block SHALL expose these ports, with AW = clog2(DEPTH):
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- wr_en  in  1  write request.
- wr_data  in  WIDTH  write word.
- rd_en  in  1  read/pop request.
- rd_data  out  WIDTH  read word.
- rd_valid  out  1  rd_data holds a valid word.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  threshold flag.
- almost_empty  out  1  threshold flag.
- level  out  AW+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.
- clr_err  in  1  clears overflow and underflow.

Function
REQ-007 rd_acc = rd_en && !empty. wr_acc = wr_en && (!full || rd_acc).
REQ-008 Write and read pointers SHALL be AW bits wide, advance by 1 on each accepted operation, and wrap DEPTH-1 -> 0 naturally.
REQ-009 level SHALL be updated as follows on each clock: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither occur.
REQ-010 full, empty, almost_full and almost_empty SHALL be decoded combinationally from the registered level, so a flag changes in the same cycle that level changes.
REQ-011 When the FIFO is full and wr_en and rd_en are both high, both operations SHALL be accepted and level SHALL stay at DEPTH.
REQ-012 When the FIFO is empty and wr_en and rd_en are both high, the write SHALL be accepted, the read SHALL be rejected, underflow SHALL set, and level SHALL become 1.
REQ-013 With FWFT=0, rd_data SHALL be registered and load the head word one cycle after rd_acc, with rd_valid high for exactly that cycle; otherwise rd_data SHALL hold its last value.
REQ-014 With FWFT=1, rd_data SHALL present the head word combinationally whenever !empty, rd_valid SHALL equal !empty, and rd_acc SHALL pop that word.
REQ-015 Write-to-read latency: a word written into an empty FIFO SHALL be readable (rd_acc possible) in the next cycle.
REQ-016 overflow SHALL set on wr_en && !wr_acc, and underflow SHALL set on rd_en && empty.
REQ-017 clr_err SHALL clear overflow and underflow; if a set condition and clr_err occur in the same cycle, the set SHALL take priority.
REQ-018 A rejected operation SHALL NOT modify the pointers, level or memory.

Reset
REQ-019 While rst is high at a clock edge, the block SHALL force: pointers 0, level 0, rd_data 0, rd_valid 0, overflow 0, underflow 0.
REQ-020 Memory contents SHALL NOT be reset.
REQ-021 A reset during operation SHALL discard all stored words.
REQ-022 wr_en and rd_en SHALL be ignored in any cycle where rst is high.

Structure
REQ-023 Shared package fifo_pkg SHALL hold the clog2 function and the FWFT mode constants (FIFO_STD=0, FIFO_FWFT=1).
REQ-024 Storage SHALL be a sub-module fifo_dp_mem: WIDTH x DEPTH, one synchronous write port, one asynchronous read port.
REQ-025 Parameter legality SHALL be checked at elaboration: DEPTH must be a power of two, and AE_THRESH < AF_THRESH <= DEPTH.

Verification
REQ-026 Bench with DEPTH=16, FWFT=0: write 16 words 0x00..0x0F -> full=1 and almost_full=1 (from level 14), level=16; a 17th write -> overflow=1, level stays 16.
REQ-027 Read 16 words -> rd_data = 0x00..0x0F in order, each one cycle after rd_en, rd_valid pulses each time; then empty=1; one more read -> underflow=1.
REQ-028 At full, assert wr_en and rd_en for 20 cycles -> level stays 16, no overflow, data order preserved across pointer wrap.
REQ-029 At empty, assert wr_en and rd_en together with 0xA5 -> level=1, underflow=1; with FWFT=1 -> rd_data=0xA5 and rd_valid=1 in the next cycle.
REQ-030 Fill to 9, then pulse rst -> level=0, empty=1, flags=0, rd_valid=0; a subsequent read -> underflow=1, returns no stale data.
REQ-031 Set overflow, then drive clr_err together with an overflowing write -> overflow remains 1; clr_err alone -> overflow=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO: read-mode constants
// and a constant-foldable ceil(log2) helper for pointer sizing.
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/fifo_dp_mem.sv
// Storage array: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module fifo_dp_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with level, threshold flags, sticky
// error flags and a selectable registered or first-word-fall-through read.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = FIFO_STD,
    localparam int AW       = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AW:0]      level,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err
);

    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   LVL_ONE = 1;
    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   AF_L    = (AW + 1)'(AF_THRESH);
    localparam logic [AW:0]   AE_L    = (AW + 1)'(AE_THRESH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("param_sync_fifo: DEPTH must be a power of two >= 2");
    end
    if (!(AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresh
        $error("param_sync_fifo: need AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             rd_acc, wr_acc;
    logic [WIDTH-1:0] head;

    assign empty        = (level_q == '0);
    assign full         = (level_q == DEPTH_L);
    assign almost_full  = (level_q >= AF_L);
    assign almost_empty = (level_q <= AE_L);
    assign level        = level_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a write.
    always_comb begin
        rd_acc   = rd_en && !empty && !rst;
        wr_acc   = wr_en && (!full || rd_acc) && !rst;
        wr_ptr_d = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        level_d  = level_q;
        case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
        ovf_d = (ovf_q && !clr_err) || (wr_en && !wr_acc);
        unf_d = (unf_q && !clr_err) || (rd_en && empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    fifo_dp_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    if (FWFT == FIFO_FWFT) begin : g_fwft
        // Gate to zero when empty so a stale slot never leaks out.
        assign rd_data  = empty ? '0 : head;
        assign rd_valid = !empty;
    end else begin : g_std
        logic [WIDTH-1:0] rd_data_q;
        logic             rd_valid_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) rd_data_q <= head;
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end

endmodule
